// File: rtl/ammrv_cache_mgr_pkg.sv
// Shared types for the Avalon-MM cache maintenance manager: op codes, status
// bit positions, FSM states and the pending-command record.
package ammrv_cache_mgr_pkg;

  typedef enum logic [1:0] {
    OP_NOP         = 2'b00,
    OP_INVAL       = 2'b01,
    OP_FLUSH       = 2'b10,
    OP_FLUSH_INVAL = 2'b11
  } op_t;

  localparam int ST_BUSY     = 0;
  localparam int ST_PEND     = 1;
  localparam int ST_BAD      = 2;
  localparam int ST_TIMEOUT  = 3;
  localparam int ST_DONE_LSB = 16;

  // Channel index is stored at full width so NCH up to 8 fits.
  localparam int CH_IDX_W = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [CH_IDX_W-1:0] ch;
    op_t                 op;
    logic [31:0]         addr;
  } cmd_t;

endpackage

// File: rtl/ammrv_cache_mgr_cmdq.sv
// One-entry pending command buffer between the Avalon write port and the FSM.
module ammrv_cache_mgr_cmdq
  import ammrv_cache_mgr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output logic valid,
  output cmd_t cmd
);

  // A push in the drain cycle replaces the outgoing entry, so it wins over pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      cmd   <= '0;
    end else if (push) begin
      valid <= 1'b1;
      cmd   <= push_cmd;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ammrv_cache_mgr.sv
// Avalon-MM front end that issues flush/invalidate requests to NCH cache channels.
// Optional request timeout is enabled by defining AMMRV_CACHE_MGR_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | no request outstanding; loads the pending command if present
// S_ISSUE | flags asserted on one channel, waiting for its ack (or timeout)
module ammrv_cache_mgr
  import ammrv_cache_mgr_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int TO_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       amm_address,
  input  logic [3:0]        amm_byteenable,
  input  logic [31:0]       amm_writedata,
  input  logic              amm_read,
  input  logic              amm_write,
  output logic              amm_waitrequest,
  output logic [31:0]       amm_readdata,
  output logic              amm_readdatavalid,
  output logic [NCH*32-1:0] cache_req_addr,
  output logic [NCH-1:0]    cache_req_flush,
  output logic [NCH-1:0]    cache_req_inval,
  input  logic [NCH-1:0]    cache_req_ack
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t              state, state_nxt;
  logic                pend_valid;
  cmd_t                pend_cmd, wr_cmd;
  logic                load, done, abandon, to_hit;
  logic                wr_acc, wr_live, wr_bad, push, set_bad;
  logic [CH_IDX_W-1:0] wr_ch, cur_ch;
  op_t                 wr_op;
  logic [NCH-1:0]      sel;
  logic [7:0]          ack_pad, done_cnt;
  logic                sticky_bad, sticky_to;
  logic [31:0]         status;
  logic                unused_ok;

  assign unused_ok = ^{amm_byteenable, amm_address[31:4+CHW], amm_address[1:0]};

  assign wr_op   = op_t'(amm_address[3:2]);
  assign wr_ch   = CH_IDX_W'(amm_address[4 +: CHW]);
  assign wr_bad  = int'(wr_ch) >= NCH;
  assign wr_cmd  = '{ch: wr_ch, op: wr_op, addr: amm_writedata};

  assign amm_waitrequest = amm_write & pend_valid & ~amm_read;
  assign wr_acc  = amm_write & ~amm_waitrequest;
  assign wr_live = wr_acc & (wr_op != OP_NOP);
  // Only a read+write on a full, non-draining buffer can fail this guard.
  assign push    = wr_live & ~wr_bad & (~pend_valid | load);
  assign set_bad = wr_live & wr_bad;

  ammrv_cache_mgr_cmdq u_cmdq (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_cmd (wr_cmd),
    .pop      (load),
    .valid    (pend_valid),
    .cmd      (pend_cmd)
  );

  assign ack_pad = 8'(cache_req_ack);

  always_comb begin
    sel = '0;
    for (int k = 0; k < NCH; k++) sel[k] = (pend_cmd.ch == CH_IDX_W'(k));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    abandon   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_valid) begin
          load      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack_pad[cur_ch]) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (to_hit) begin
          abandon   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_req_flush <= '0;
      cache_req_inval <= '0;
      cache_req_addr  <= '0;
      cur_ch          <= '0;
      done_cnt        <= '0;
      sticky_bad      <= 1'b0;
    end else begin
      if (load) begin
        cur_ch          <= pend_cmd.ch;
        cache_req_flush <= sel & {NCH{pend_cmd.op[1]}};
        cache_req_inval <= sel & {NCH{pend_cmd.op[0]}};
        for (int k = 0; k < NCH; k++)
          if (sel[k]) cache_req_addr[32*k +: 32] <= pend_cmd.addr;
      end else if (done || abandon) begin
        cache_req_flush <= '0;
        cache_req_inval <= '0;
      end
      if (done) done_cnt <= done_cnt + 8'd1;
      sticky_bad <= set_bad | (sticky_bad & ~amm_read);
    end
  end

`ifdef AMMRV_CACHE_MGR_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - TO_W'(1);
  logic [TO_W-1:0] to_cnt;

  // Abandon on the edge where the counter steps onto its all-ones value.
  assign to_hit = (state == S_ISSUE) && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      sticky_to <= 1'b0;
    end else begin
      if (load)                  to_cnt <= '0;
      else if (state == S_ISSUE) to_cnt <= to_cnt + TO_W'(1);
      sticky_to <= abandon | (sticky_to & ~amm_read);
    end
  end
`else
  logic [TO_W-1:0] unused_to;
  assign unused_to = '0;
  assign to_hit    = 1'b0;
  assign sticky_to = 1'b0;
`endif

  always_comb begin
    status                         = '0;
    status[ST_BUSY]                = (state != S_IDLE);
    status[ST_PEND]                = pend_valid;
    status[ST_BAD]                 = sticky_bad;
    status[ST_TIMEOUT]             = sticky_to;
    status[ST_DONE_LSB +: 8]       = done_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      amm_readdatavalid <= 1'b0;
      amm_readdata      <= '0;
    end else begin
      amm_readdatavalid <= amm_read;
      if (amm_read) amm_readdata <= status;
    end
  end

endmodule

// File: tb/tb_ammrv_cache_mgr.sv
// Self-checking bench for ammrv_cache_mgr (NCH=3, TO_W=4) with a scoreboard
// of accepted commands and randomized traffic.
module tb_ammrv_cache_mgr;

  localparam int NCH  = 3;
  localparam int TO_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       amm_address, amm_writedata, amm_readdata;
  logic [3:0]        amm_byteenable;
  logic              amm_read, amm_write, amm_waitrequest, amm_readdatavalid;
  logic [NCH*32-1:0] cache_req_addr;
  logic [NCH-1:0]    cache_req_flush, cache_req_inval, cache_req_ack;

  ammrv_cache_mgr #(.NCH(NCH), .TO_W(TO_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .amm_address       (amm_address),
    .amm_byteenable    (amm_byteenable),
    .amm_writedata     (amm_writedata),
    .amm_read          (amm_read),
    .amm_write         (amm_write),
    .amm_waitrequest   (amm_waitrequest),
    .amm_readdata      (amm_readdata),
    .amm_readdatavalid (amm_readdatavalid),
    .cache_req_addr    (cache_req_addr),
    .cache_req_flush   (cache_req_flush),
    .cache_req_inval   (cache_req_inval),
    .cache_req_ack     (cache_req_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    int          op;
    logic [31:0] addr;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  exp_t exp_q[$];
  int   exp_done = 0;
  bit   exp_bad  = 0;
  int   acc_cyc[0:511];
  int   first_ack_cyc;
  bit   writer_done;

  always @(posedge clk) cycle++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status(int busy, int pend, int bad, int to, int done);
    return 32'(busy + pend * 2 + bad * 4 + to * 8 + (done % 256) * 65536);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int acc);
    bit ok = 0;
    amm_address    = a;
    amm_writedata  = d;
    amm_byteenable = 4'($urandom);
    amm_write      = 1'b1;
    acc            = -1;
    for (int i = 0; i < 64 && !ok; i++) begin
      #1;
      ok = !amm_waitrequest;
      tick;
    end
    amm_write = 1'b0;
    if (ok) acc = cycle;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_accept: addr %h still stalled after 64 cycles, required acceptance", a);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; amm_read = 1'b1; amm_write = 1'b0; amm_address = '0;
    amm_writedata = '0; amm_byteenable = '0; cache_req_ack = '0;
    repeat (3) tick;
    checks++;
    if ({cache_req_flush, cache_req_inval, amm_readdatavalid, amm_waitrequest} !== '0 ||
        cache_req_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flush=%b inval=%b rdv=%b wr=%b addr=%h, required all 0",
               cache_req_flush, cache_req_inval, amm_readdatavalid, amm_waitrequest, cache_req_addr);
    end
    amm_read = 1'b0; reset = 1'b0;
    tick;
    amm_read = 1'b1; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdatavalid !== 1'b1 || amm_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: rdv=%b data=%h, required 1 / 00000000", amm_readdatavalid, amm_readdata);
    end
    tick;
  endtask

  task automatic test_single;
    amm_address = 32'h14; amm_writedata = 32'h8000_0000; amm_write = 1'b1;
    #1;
    checks++;
    if (amm_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: waitrequest=%b, required 0", amm_waitrequest);
    end
    tick;
    amm_write = 1'b0;
    checks++;
    if ((cache_req_flush | cache_req_inval) !== '0) begin
      errors++;
      $display("FAIL single_early: flags=%b, required 000 one cycle after write", cache_req_flush | cache_req_inval);
    end
    tick;
    checks++;
    if (cache_req_inval !== 3'b010 || cache_req_flush !== 3'b000 || cache_req_addr[63:32] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL single_issue: inval=%b flush=%b addr1=%h, required 010 000 80000000",
               cache_req_inval, cache_req_flush, cache_req_addr[63:32]);
    end
    cache_req_ack = 3'b101;
    tick;
    checks++;
    if (cache_req_inval !== 3'b010) begin
      errors++;
      $display("FAIL single_other_ack: inval=%b, required 010 (foreign acks ignored)", cache_req_inval);
    end
    cache_req_ack = 3'b010;
    tick;
    cache_req_ack = '0;
    exp_done++;
    checks++;
    if ((cache_req_flush | cache_req_inval) !== '0) begin
      errors++;
      $display("FAIL single_clear: flags=%b, required 000 after ack", cache_req_flush | cache_req_inval);
    end
    amm_read = 1'b1; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdatavalid !== 1'b1 || amm_readdata !== exp_status(0, 0, 0, 0, exp_done)) begin
      errors++;
      $display("FAIL single_status: rdv=%b data=%h, required 1 / %h", amm_readdatavalid, amm_readdata,
               exp_status(0, 0, 0, 0, exp_done));
    end
    tick;
    checks++;
    if (amm_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rdv_pulse: rdv=%b, required 0 one cycle after the response", amm_readdatavalid);
    end
  endtask

  task automatic test_bad_channel;
    logic [31:0] d1, d2;
    bit          v1, v2;
    amm_address = 32'h3C; amm_writedata = $urandom; amm_write = 1'b1;
    tick;
    amm_write = 1'b0;
    repeat (2) tick;
    checks++;
    if ((cache_req_flush | cache_req_inval) !== '0) begin
      errors++;
      $display("FAIL bad_no_req: flags=%b, required 000", cache_req_flush | cache_req_inval);
    end
    amm_read = 1'b1;
    tick; d1 = amm_readdata; v1 = amm_readdatavalid;
    tick; d2 = amm_readdata; v2 = amm_readdatavalid;
    amm_read = 1'b0;
    checks++;
    if (v1 !== 1'b1 || v2 !== 1'b1 || d1 !== exp_status(0, 0, 1, 0, exp_done) ||
        d2 !== exp_status(0, 0, 0, 0, exp_done)) begin
      errors++;
      $display("FAIL bad_sticky: rdv=%b%b data=%h/%h, required 11 %h/%h", v1, v2, d1, d2,
               exp_status(0, 0, 1, 0, exp_done), exp_status(0, 0, 0, 0, exp_done));
    end
    amm_address = 32'h3C; amm_write = 1'b1; amm_read = 1'b1;
    tick;
    amm_write = 1'b0;
    tick; amm_read = 1'b0;
    checks++;
    if (amm_readdata !== exp_status(0, 0, 1, 0, exp_done)) begin
      errors++;
      $display("FAIL bad_set_wins: data=%h, required %h", amm_readdata, exp_status(0, 0, 1, 0, exp_done));
    end
    tick;
  endtask

  task automatic run_traffic(input int n, input bit fixed_ch0, input int dmin, input int dmax);
    writer_done   = 0;
    first_ack_cyc = -1;
    fork
      begin : writer
        for (int i = 0; i < n; i++) begin
          int          ch, op, acc;
          logic [31:0] a;
          if (fixed_ch0) begin
            ch = 0; op = 2;
          end else begin
            ch = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            op = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
            repeat ($urandom_range(0, 2)) tick;
          end
          a = 32'(ch * 16 + op * 4);
          do_write(a, $urandom, acc);
          acc_cyc[i] = acc;
          if (acc >= 0 && op != 0) begin
            if (ch >= NCH) exp_bad = 1;
            else exp_q.push_back('{ch: ch, op: op, addr: amm_writedata});
          end
        end
        writer_done = 1;
      end
      begin : monitor
        bit          active = 0, ack_last = 0, fin = 0;
        int          delay = 0, cur = 0;
        logic [2:0]  cur_fl = '0, cur_in = '0;
        logic [31:0] cur_addr = '0;
        for (int c = 0; c < n * 40 + 100 && !fin; c++) begin
          logic [2:0] f;
          f = cache_req_flush | cache_req_inval;
          if (ack_last) begin
            ack_last = 0; active = 0;
            checks++;
            if (f !== '0) begin
              errors++;
              $display("FAIL req_release: flags=%b, required 000 the cycle after ack", f);
            end else exp_done++;
          end else if (active) begin
            checks++;
            if (cache_req_flush !== cur_fl || cache_req_inval !== cur_in ||
                cache_req_addr[32*cur +: 32] !== cur_addr) begin
              errors++;
              $display("FAIL req_hold: flush=%b inval=%b addr=%h, required %b %b %h",
                       cache_req_flush, cache_req_inval, cache_req_addr[32*cur +: 32], cur_fl, cur_in, cur_addr);
            end
          end else if (f !== '0) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL req_spurious: flags=%b, required 000 (no command outstanding)", f);
            end else begin
              exp_t e = exp_q.pop_front();
              cur      = e.ch;
              cur_fl   = (e.op >= 2) ? 3'(1 << e.ch) : 3'b000;
              cur_in   = (e.op % 2 == 1) ? 3'(1 << e.ch) : 3'b000;
              cur_addr = e.addr;
              if (cache_req_flush !== cur_fl || cache_req_inval !== cur_in ||
                  cache_req_addr[32*cur +: 32] !== cur_addr) begin
                errors++;
                $display("FAIL req_issue: flush=%b inval=%b addr=%h, required %b %b %h",
                         cache_req_flush, cache_req_inval, cache_req_addr[32*cur +: 32], cur_fl, cur_in, cur_addr);
              end
              active = 1;
              delay  = $urandom_range(dmin, dmax);
            end
          end
          if (writer_done && exp_q.size() == 0 && !active) begin
            fin = 1;
            cache_req_ack = '0;
          end else if (active) begin
            logic [2:0] noise, mine;
            noise = 3'($urandom_range(0, 7));
            mine  = 3'(1 << cur);
            if (delay == 0) begin
              cache_req_ack = mine | noise;
              ack_last = 1;
              if (first_ack_cyc < 0) first_ack_cyc = cycle;
            end else begin
              delay--;
              cache_req_ack = noise & ~mine;
            end
          end else cache_req_ack = 3'($urandom_range(0, 7));
          if (!fin) tick;
        end
        checks++;
        if (!fin) begin
          errors++;
          $display("FAIL traffic_drain: %0d commands outstanding, required 0 within budget", exp_q.size());
        end
      end
    join
    cache_req_ack = '0;
    tick;
    amm_read = 1'b1; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdatavalid !== 1'b1 || amm_readdata !== exp_status(0, 0, int'(exp_bad), 0, exp_done)) begin
      errors++;
      $display("FAIL traffic_status: rdv=%b data=%h, required 1 / %h", amm_readdatavalid, amm_readdata,
               exp_status(0, 0, int'(exp_bad), 0, exp_done));
    end
    exp_bad = 0;
    tick;
  endtask

  task automatic test_back_to_back;
    run_traffic(3, 1'b1, 8, 8);
    checks++;
    if (!(acc_cyc[1] - acc_cyc[0] > 1 && acc_cyc[2] > first_ack_cyc + 1)) begin
      errors++;
      $display("FAIL b2b_stall: accept cycles %0d %0d %0d first ack %0d, required 3rd accepted after first ack",
               acc_cyc[0], acc_cyc[1], acc_cyc[2], first_ack_cyc);
    end
  endtask

  task automatic test_timeout;
    int high = 0;
    amm_address = 32'h18; amm_writedata = $urandom; amm_write = 1'b1;
    tick;
    amm_write = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if ((cache_req_flush | cache_req_inval) !== '0) high++;
      else break;
    end
`ifdef AMMRV_CACHE_MGR_TIMEOUT_EN
    checks++;
    if (high != 15) begin
      errors++;
      $display("FAIL timeout_len: flags high %0d cycles, required 15", high);
    end
    amm_read = 1'b1; tick; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdata !== exp_status(0, 0, 0, 0, exp_done)) begin
      errors++;
      $display("FAIL timeout_clear: second read %h, required %h", amm_readdata, exp_status(0, 0, 0, 0, exp_done));
    end
    // first of the two reads is checked via a fresh abandon below
    amm_address = 32'h18; amm_write = 1'b1; tick; amm_write = 1'b0;
    repeat (20) tick;
    amm_read = 1'b1; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdata !== exp_status(0, 0, 0, 1, exp_done)) begin
      errors++;
      $display("FAIL timeout_sticky: data=%h, required %h", amm_readdata, exp_status(0, 0, 0, 1, exp_done));
    end
`else
    checks++;
    if (high != 40) begin
      errors++;
      $display("FAIL wait_forever: flags high %0d cycles, required 40 (no timeout)", high);
    end
    amm_read = 1'b1; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdata !== exp_status(1, 0, 0, 0, exp_done)) begin
      errors++;
      $display("FAIL wait_status: data=%h, required %h", amm_readdata, exp_status(1, 0, 0, 0, exp_done));
    end
    cache_req_ack = 3'b010; tick; cache_req_ack = '0;
    exp_done++;
    checks++;
    if ((cache_req_flush | cache_req_inval) !== '0) begin
      errors++;
      $display("FAIL wait_ack: flags=%b, required 000", cache_req_flush | cache_req_inval);
    end
`endif
    tick;
  endtask

  task automatic test_random_traffic;
    for (int b = 0; b < 5; b++) run_traffic(100, 1'b0, 0, 8);
  endtask

  task automatic test_reset_mid_issue;
    int acc;
    amm_address = 32'h2C; amm_writedata = $urandom; amm_write = 1'b1;
    tick;
    do_write(32'h24, $urandom, acc);
    amm_read = 1'b1; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdata !== exp_status(1, 1, 0, 0, exp_done) || cache_req_flush !== 3'b100 ||
        cache_req_inval !== 3'b100) begin
      errors++;
      $display("FAIL mid_pre: data=%h flush=%b inval=%b, required %h 100 100", amm_readdata,
               cache_req_flush, cache_req_inval, exp_status(1, 1, 0, 0, exp_done));
    end
    reset = 1'b1; amm_read = 1'b1;
    tick;
    amm_read = 1'b0;
    checks++;
    if ((cache_req_flush | cache_req_inval) !== '0 || cache_req_addr !== '0 || amm_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: flags=%b addr=%h rdv=%b, required 000 0 0",
               cache_req_flush | cache_req_inval, cache_req_addr, amm_readdatavalid);
    end
    reset = 1'b0;
    exp_done = 0;
    cache_req_ack = 3'b100;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if ((cache_req_flush | cache_req_inval) !== '0) begin
        errors++;
        $display("FAIL mid_ack_ignored: flags=%b, required 000", cache_req_flush | cache_req_inval);
      end
    end
    cache_req_ack = '0;
    amm_read = 1'b1; tick; amm_read = 1'b0;
    checks++;
    if (amm_readdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_status: data=%h, required 00000000", amm_readdata);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_bad_channel;
    test_back_to_back;
    test_timeout;
    test_random_traffic;
    test_reset_mid_issue;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
